// File: rtl/rvh_l1d_ld_wb_arb_if.sv
//------------------------------------------------------------------------------
// Module : rvh_l1d_ld_wb_arb_if
// Purpose: Bundles the hit-response, MLFB refill-replay and core writeback
//          signals of the L1D load writeback arbiter.
// Ports  : slave  - arbiter side (takes hit/refill, drives writeback)
//          master - environment side (drives hit/refill, takes writeback)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface rvh_l1d_ld_wb_arb_if #(
  parameter int unsigned REFILL_Q_DEPTH = 4,
  parameter int unsigned ROB_TAG_W      = 4,
  parameter int unsigned PREG_TAG_W     = 6,
  parameter int unsigned XLEN           = 64
);
  localparam int unsigned CNT_W = $clog2(REFILL_Q_DEPTH) + 1;

  // hit-response stage
  logic                  hit_vld_i;
  logic                  hit_rdy_o;
  logic [ROB_TAG_W-1:0]  hit_rob_tag_i;
  logic [PREG_TAG_W-1:0] hit_prd_i;
  logic [XLEN-1:0]       hit_data_i;
  // MLFB refill replay
  logic                  refill_vld_i;
  logic                  refill_rdy_o;
  logic [ROB_TAG_W-1:0]  refill_rob_tag_i;
  logic [PREG_TAG_W-1:0] refill_prd_i;
  logic [XLEN-1:0]       refill_data_i;
  // core writeback bus
  logic                  l1d_rob_wb_vld_o;
  logic [ROB_TAG_W-1:0]  l1d_rob_wb_rob_tag_o;
  logic                  l1d_int_prf_wb_vld_o;
  logic [PREG_TAG_W-1:0] l1d_int_prf_wb_tag_o;
  logic [XLEN-1:0]       l1d_int_prf_wb_data_o;
  logic                  l1d_int_prf_wb_vld_from_mlfb_o;
  logic [CNT_W-1:0]      refill_q_cnt_o;

  modport slave (
    input  hit_vld_i, hit_rob_tag_i, hit_prd_i, hit_data_i,
    input  refill_vld_i, refill_rob_tag_i, refill_prd_i, refill_data_i,
    output hit_rdy_o, refill_rdy_o,
    output l1d_rob_wb_vld_o, l1d_rob_wb_rob_tag_o,
    output l1d_int_prf_wb_vld_o, l1d_int_prf_wb_tag_o, l1d_int_prf_wb_data_o,
    output l1d_int_prf_wb_vld_from_mlfb_o, refill_q_cnt_o
  );

  modport master (
    output hit_vld_i, hit_rob_tag_i, hit_prd_i, hit_data_i,
    output refill_vld_i, refill_rob_tag_i, refill_prd_i, refill_data_i,
    input  hit_rdy_o, refill_rdy_o,
    input  l1d_rob_wb_vld_o, l1d_rob_wb_rob_tag_o,
    input  l1d_int_prf_wb_vld_o, l1d_int_prf_wb_tag_o, l1d_int_prf_wb_data_o,
    input  l1d_int_prf_wb_vld_from_mlfb_o, refill_q_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/rvh_l1d_ld_wb_arb.sv
//------------------------------------------------------------------------------
// Module : rvh_l1d_ld_wb_arb
// Purpose: Arbitrates the single L1D load writeback port between the bank
//          hit-response stage (unbufferable, normally wins) and MLFB refill
//          replays (queued in a small FIFO, drained in hit-idle slots).
//          All writeback outputs are registered.
// Ports  : clk, rst (sync, active-high), flush_i (drop all in-flight work),
//          bus (rvh_l1d_ld_wb_arb_if.slave: hit / refill / writeback).
// Config : RVH_L1D_WB_ARB_STARVE_EN - when defined, after STARVE_LIMIT
//          consecutive hit grants with a refill pending, the hit stage is
//          stalled for one cycle so the FIFO head writes back.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rvh_l1d_ld_wb_arb #(
  parameter int unsigned REFILL_Q_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 8,
  parameter int unsigned ROB_TAG_W      = 4,
  parameter int unsigned PREG_TAG_W     = 6,
  parameter int unsigned XLEN           = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  rvh_l1d_ld_wb_arb_if.slave    bus
);
  localparam int unsigned c_ptr_w = $clog2(REFILL_Q_DEPTH);
  localparam int unsigned c_cnt_w = c_ptr_w + 1;

  if ((REFILL_Q_DEPTH < 2) || ((REFILL_Q_DEPTH & (REFILL_Q_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("REFILL_Q_DEPTH must be a power of two >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be >= 1");
  end

  // refill FIFO
  logic [ROB_TAG_W-1:0]  r_q_rob  [REFILL_Q_DEPTH];
  logic [PREG_TAG_W-1:0] r_q_prd  [REFILL_Q_DEPTH];
  logic [XLEN-1:0]       r_q_data [REFILL_Q_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_cnt;

  // writeback output register
  logic                  r_wb_vld;
  logic [ROB_TAG_W-1:0]  r_wb_rob;
  logic [PREG_TAG_W-1:0] r_wb_prd;
  logic [XLEN-1:0]       r_wb_data;
  logic                  r_wb_mlfb;

  logic w_q_nonempty;
  logic w_q_full;
  logic w_force;
  logic w_grant_hit;
  logic w_grant_refill;
  logic w_enq;
  logic w_deq;

  // Full/empty come from the registered count only, so a same-cycle
  // dequeue never frees a slot for an enqueue.
  assign w_q_nonempty = (r_cnt != '0);
  assign w_q_full     = (r_cnt == c_cnt_w'(REFILL_Q_DEPTH));

`ifdef RVH_L1D_WB_ARB_STARVE_EN
  localparam int unsigned c_sw = $clog2(STARVE_LIMIT + 1);
  logic [c_sw-1:0] r_starve_cnt;

  assign w_force = w_q_nonempty & (r_starve_cnt == c_sw'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst || flush_i || w_grant_refill || !w_q_nonempty) begin
      r_starve_cnt <= '0;
    end else if (w_grant_hit && (r_starve_cnt != c_sw'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + c_sw'(1);
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_grant_hit    = bus.hit_vld_i & ~w_force;
  assign w_grant_refill = w_q_nonempty & (~bus.hit_vld_i | w_force);
  assign w_enq          = bus.refill_vld_i & ~w_q_full & ~flush_i;
  assign w_deq          = w_grant_refill;

  assign bus.hit_rdy_o    = ~w_force;
  assign bus.refill_rdy_o = ~w_q_full;

  // FIFO storage: no reset needed, entries are qualified by r_cnt.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_rob[r_wr_ptr]  <= bus.refill_rob_tag_i;
      r_q_prd[r_wr_ptr]  <= bus.refill_prd_i;
      r_q_data[r_wr_ptr] <= bus.refill_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_cnt <= r_cnt + c_cnt_w'(w_enq) - c_cnt_w'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_vld  <= 1'b0;
      r_wb_rob  <= '0;
      r_wb_prd  <= '0;
      r_wb_data <= '0;
      r_wb_mlfb <= 1'b0;
    end else begin
      r_wb_vld  <= (w_grant_hit | w_grant_refill) & ~flush_i;
      r_wb_mlfb <= w_grant_refill & ~flush_i;
      if (w_grant_hit) begin
        r_wb_rob  <= bus.hit_rob_tag_i;
        r_wb_prd  <= bus.hit_prd_i;
        r_wb_data <= bus.hit_data_i;
      end else if (w_grant_refill) begin
        r_wb_rob  <= r_q_rob[r_rd_ptr];
        r_wb_prd  <= r_q_prd[r_rd_ptr];
        r_wb_data <= r_q_data[r_rd_ptr];
      end
    end
  end

  assign bus.l1d_rob_wb_vld_o               = r_wb_vld;
  assign bus.l1d_rob_wb_rob_tag_o           = r_wb_rob;
  assign bus.l1d_int_prf_wb_vld_o           = r_wb_vld;
  assign bus.l1d_int_prf_wb_tag_o           = r_wb_prd;
  assign bus.l1d_int_prf_wb_data_o          = r_wb_data;
  assign bus.l1d_int_prf_wb_vld_from_mlfb_o = r_wb_mlfb;
  assign bus.refill_q_cnt_o                 = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rvh_l1d_ld_wb_arb.sv
//------------------------------------------------------------------------------
// Module : tb_rvh_l1d_ld_wb_arb
// Purpose: Scoreboard bench for rvh_l1d_ld_wb_arb. A queue-level reference
//          model predicts each writeback (with its cycle stamp) as stimulus
//          is issued; a monitor pops and compares on every DUT writeback.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rvh_l1d_ld_wb_arb;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;
  localparam int unsigned RW    = 4;
  localparam int unsigned PW    = 6;
  localparam int unsigned XW    = 64;
`ifdef RVH_L1D_WB_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  typedef struct {
    logic [RW-1:0] rob;
    logic [PW-1:0] prd;
    logic [XW-1:0] data;
  } pay_t;

  typedef struct {
    int            cyc;
    logic [RW-1:0] rob;
    logic [PW-1:0] prd;
    logic [XW-1:0] data;
    logic          mlfb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];     // expected writebacks, in order
  pay_t mq[$];     // model of the refill queue contents
  int   mstarve;   // model: consecutive hit grants with refill pending

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rvh_l1d_ld_wb_arb_if #(.REFILL_Q_DEPTH(DEPTH), .ROB_TAG_W(RW), .PREG_TAG_W(PW), .XLEN(XW)) bus ();

  rvh_l1d_ld_wb_arb #(
    .REFILL_Q_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT),
    .ROB_TAG_W(RW), .PREG_TAG_W(PW), .XLEN(XW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the model predicts its effect.
  task automatic step(input bit hv, input pay_t hp, input bit rv, input pay_t rp, input bit fl);
    bit   force_m;
    bit   full_m;
    bit   nonempty_m;
    exp_t e;
    pay_t p;
    @(negedge clk);
    force_m    = STARVE_EN && (mq.size() > 0) && (mstarve == LIMIT);
    full_m     = (mq.size() >= DEPTH);
    nonempty_m = (mq.size() > 0);
    chk("hit_rdy", 64'(bus.hit_rdy_o), 64'(!force_m));
    chk("refill_rdy", 64'(bus.refill_rdy_o), 64'(!full_m));
    chk("q_cnt", 64'(bus.refill_q_cnt_o), 64'(mq.size()));

    bus.hit_vld_i        = hv;
    bus.hit_rob_tag_i    = hp.rob;
    bus.hit_prd_i        = hp.prd;
    bus.hit_data_i       = hp.data;
    bus.refill_vld_i     = rv;
    bus.refill_rob_tag_i = rp.rob;
    bus.refill_prd_i     = rp.prd;
    bus.refill_data_i    = rp.data;
    flush                = fl;

    if (fl) begin
      mq.delete();
      mstarve = 0;
    end else begin
      if (hv && !force_m) begin
        e.cyc = cyc + 1; e.rob = hp.rob; e.prd = hp.prd; e.data = hp.data; e.mlfb = 1'b0;
        sb.push_back(e);
        if (!nonempty_m) mstarve = 0;
        else if (mstarve < LIMIT) mstarve++;
      end else if (nonempty_m) begin
        p = mq.pop_front();
        e.cyc = cyc + 1; e.rob = p.rob; e.prd = p.prd; e.data = p.data; e.mlfb = 1'b1;
        sb.push_back(e);
        mstarve = 0;
      end else begin
        mstarve = 0;
      end
      if (rv && !full_m) mq.push_back(rp);
    end
  endtask

  function automatic pay_t rnd_pay();
    pay_t p;
    p.rob  = RW'($urandom);
    p.prd  = PW'($urandom);
    p.data = {$urandom, $urandom};
    return p;
  endfunction

  task automatic rstep(input bit hv, input bit rv, input bit fl);
    step(hv, rnd_pay(), rv, rnd_pay(), fl);
  endtask

  // Monitor: compare every DUT writeback against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          checks++; errors++;
          $display("FAIL missing_wb: got none expected rob %0h at cycle %0d", e.rob, e.cyc);
        end
        if (bus.l1d_int_prf_wb_vld_o !== bus.l1d_rob_wb_vld_o) begin
          checks++; errors++;
          $display("FAIL prf_vld: got %0b expected %0b", bus.l1d_int_prf_wb_vld_o, bus.l1d_rob_wb_vld_o);
        end
        if (bus.l1d_rob_wb_vld_o === 1'b1) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_wb: got rob %0h expected none (cycle %0d)", bus.l1d_rob_wb_rob_tag_o, cyc);
          end else begin
            e = sb.pop_front();
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
            chk("wb_rob", 64'(bus.l1d_rob_wb_rob_tag_o), 64'(e.rob));
            chk("wb_prd", 64'(bus.l1d_int_prf_wb_tag_o), 64'(e.prd));
            chk("wb_data", bus.l1d_int_prf_wb_data_o, e.data);
            chk("wb_mlfb", 64'(bus.l1d_int_prf_wb_vld_from_mlfb_o), 64'(e.mlfb));
          end
        end
      end
    end
  end

  initial begin
    pay_t hp;
    pay_t zp;
    int   ph;
    int   pr;
    zp = '{rob: '0, prd: '0, data: '0};
    rst = 1'b1;
    flush = 1'b0;
    bus.hit_vld_i = 1'b0; bus.hit_rob_tag_i = '0; bus.hit_prd_i = '0; bus.hit_data_i = '0;
    bus.refill_vld_i = 1'b0; bus.refill_rob_tag_i = '0; bus.refill_prd_i = '0; bus.refill_data_i = '0;
    mstarve = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rob_vld", 64'(bus.l1d_rob_wb_vld_o), 64'd0);
    chk("rst_prf_vld", 64'(bus.l1d_int_prf_wb_vld_o), 64'd0);
    chk("rst_mlfb", 64'(bus.l1d_int_prf_wb_vld_from_mlfb_o), 64'd0);
    chk("rst_refill_rdy", 64'(bus.refill_rdy_o), 64'd1);
    chk("rst_hit_rdy", 64'(bus.hit_rdy_o), 64'd1);
    chk("rst_q_cnt", 64'(bus.refill_q_cnt_o), 64'd0);
    chk("rst_data", bus.l1d_int_prf_wb_data_o, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // lone hit
    hp = '{rob: 4'd3, prd: 6'h12, data: 64'hDEAD};
    step(1'b1, hp, 1'b0, zp, 1'b0);
    rstep(1'b0, 1'b0, 1'b0);

    // fill to full under continuous hits, then drain
    repeat (5) rstep(1'b1, 1'b1, 1'b0);
    repeat (DEPTH + 2) rstep(1'b0, 1'b0, 1'b0);

    // starvation: one refill pending under a hit stream
    rstep(1'b0, 1'b1, 1'b0);
    repeat (LIMIT + 4) rstep(1'b1, 1'b0, 1'b0);
    repeat (2) rstep(1'b0, 1'b0, 1'b0);

    // simultaneous hit + refill with empty queue
    rstep(1'b1, 1'b1, 1'b0);
    repeat (2) rstep(1'b0, 1'b0, 1'b0);

    // build occupancy under hits, flush with a hit valid, then a normal refill
    repeat (3) rstep(1'b1, 1'b1, 1'b0);
    rstep(1'b1, 1'b1, 1'b1);
    rstep(1'b0, 1'b1, 1'b0);
    repeat (2) rstep(1'b0, 1'b0, 1'b0);

    // randomized phases with varying hit / refill pressure
    for (int ph_i = 0; ph_i < 6; ph_i++) begin
      ph = (ph_i % 3 == 0) ? 95 : (ph_i % 3 == 1) ? 60 : 20;
      pr = (ph_i < 3) ? 70 : 35;
      repeat (400) begin
        rstep($urandom_range(99) < ph, $urandom_range(99) < pr, $urandom_range(99) < 2);
      end
    end

    repeat (DEPTH + 3) rstep(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
